// File: rtl/mailbox_pkg.sv
// -----------------------------------------------------------------------------
// mailbox_pkg
// Shared definitions for the on-chip SRAM mailbox. The writer (producer) and
// the DPS reader (consumer) both use these constants, so the word layout and
// address map are defined in one place only.
//   Address map : 0 = ready flag, 1 = point count, 2.. = packed points
//   Point word  : [29:20] x, [17:8] y, [7:0] val, remaining bits zero
//   Count word  : [8:0] count, remaining bits zero
// -----------------------------------------------------------------------------
package mailbox_pkg;

    localparam logic [7:0] ADDR_FLAG  = 8'd0;
    localparam logic [7:0] ADDR_COUNT = 8'd1;
    localparam logic [7:0] ADDR_DATA0 = 8'd2;

    localparam int X_MSB   = 29;
    localparam int X_LSB   = 20;
    localparam int Y_MSB   = 17;
    localparam int Y_LSB   = 8;
    localparam int VAL_MSB = 7;
    localparam int VAL_LSB = 0;

    localparam int COUNT_W = 9;

    // Writer FSM encoding (kept as plain constants for compatibility with the
    // older reader-side code that compares against raw state values).
    typedef logic [2:0] state_t;
    localparam state_t ST_POLL_SET  = 3'd0;
    localparam state_t ST_POLL_WAIT = 3'd1;
    localparam state_t ST_POLL_CHK  = 3'd2;
    localparam state_t ST_GAP       = 3'd3;
    localparam state_t ST_ACCEPT    = 3'd4;
    localparam state_t ST_WR_CNT    = 3'd5;
    localparam state_t ST_WR_FLAG   = 3'd6;

    // Pack one point into a mailbox data word; unused bits stay zero.
    function automatic logic [31:0] pack_point(input logic [9:0] x,
                                               input logic [9:0] y,
                                               input logic [7:0] val);
        logic [31:0] word_s;
        word_s                  = 32'd0;
        word_s[X_MSB:X_LSB]     = x;
        word_s[Y_MSB:Y_LSB]     = y;
        word_s[VAL_MSB:VAL_LSB] = val;
        return word_s;
    endfunction

    // Build the count word written to ADDR_COUNT.
    function automatic logic [31:0] count_word(input logic [COUNT_W-1:0] count);
        return {{(32 - COUNT_W){1'b0}}, count};
    endfunction

endpackage

// File: rtl/sram_mailbox_writer.sv
// -----------------------------------------------------------------------------
// sram_mailbox_writer
// Producer side of the dual-port SRAM mailbox. Polls the ready flag at
// address 0; once the consumer has cleared it, accepts up to MAX_PTS points,
// writes them as packed words at addresses 2.., then writes the count to
// address 1 and finally the flag to address 0. The flag is always the last
// word of a batch, so the consumer can never see a set flag with a stale count.
//
// Ports
//   clock, reset      : system clock, synchronous active-high reset
//   in_valid/in_ready : point stream handshake (in_x, in_y, in_val, in_last)
//   sram_address      : mailbox address (8 bits)
//   sram_write        : one-cycle write strobe per word
//   sram_writedata    : write data
//   sram_readdata     : read data, valid two cycles after the address
//   busy              : high whenever the FSM is not accepting points
//   batch_sent        : pulse coincident with the flag write
//   overflow          : pulse when a batch is cut at MAX_PTS without in_last
//
// All outputs are registered, so each state's bus action appears on the SRAM
// port one cycle after the FSM decides it.
// -----------------------------------------------------------------------------
module sram_mailbox_writer
    import mailbox_pkg::*;
#(
    parameter int MAX_PTS    = 254,
    parameter int POLL_GAP   = 16,
    parameter int FLAG_VALUE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  in_x,
    input  logic [9:0]  in_y,
    input  logic [7:0]  in_val,
    input  logic        in_last,
    output logic [7:0]  sram_address,
    output logic        sram_write,
    output logic [31:0] sram_writedata,
    input  logic [31:0] sram_readdata,
    output logic        busy,
    output logic        batch_sent,
    output logic        overflow
);

    localparam int                 GAP_W     = 16;
    localparam logic [COUNT_W-1:0] MAX_CNT   = COUNT_W'(MAX_PTS);
    localparam logic [GAP_W-1:0]   GAP_LOAD  = (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : {GAP_W{1'b0}};
    localparam logic [31:0]        FLAG_WORD = 32'(FLAG_VALUE);

    state_t               state_r;
    logic [COUNT_W-1:0]   count_r;
    logic [GAP_W-1:0]     gap_cnt_r;
    logic                 in_ready_r;
    logic [7:0]           sram_address_r;
    logic                 sram_write_r;
    logic [31:0]          sram_writedata_r;
    logic                 busy_r;
    logic                 batch_sent_r;
    logic                 overflow_r;

    state_t               state_s;
    logic [COUNT_W-1:0]   count_s;
    logic [COUNT_W-1:0]   count_inc_s;
    logic [GAP_W-1:0]     gap_cnt_s;
    logic                 in_ready_s;
    logic [7:0]           sram_address_s;
    logic                 sram_write_s;
    logic [31:0]          sram_writedata_s;
    logic                 batch_sent_s;
    logic                 overflow_s;
    logic                 handshake_s;
    logic                 batch_full_s;

    assign handshake_s  = in_valid && in_ready_r;
    assign count_inc_s  = count_r + {{(COUNT_W - 1){1'b0}}, 1'b1};
    assign batch_full_s = (count_inc_s == MAX_CNT);

    // Next-state and next-output decode for the mailbox writer FSM.
    always_comb begin
        state_s          = state_r;
        count_s          = count_r;
        gap_cnt_s        = gap_cnt_r;
        in_ready_s       = 1'b0;
        // Non-writing cycles park the address on the flag, so the flag is
        // already on the bus when a poll starts.
        sram_address_s   = ADDR_FLAG;
        sram_write_s     = 1'b0;
        sram_writedata_s = sram_writedata_r;
        batch_sent_s     = 1'b0;
        overflow_s       = 1'b0;

        case (state_r)
            ST_POLL_SET: begin
                state_s = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                state_s = ST_POLL_CHK;
            end
            ST_POLL_CHK: begin
                if (sram_readdata == 32'd0) begin
                    state_s    = ST_ACCEPT;
                    count_s    = {COUNT_W{1'b0}};
                    // Registered ready: high from the first ACCEPT cycle.
                    in_ready_s = 1'b1;
                end else if (POLL_GAP == 0) begin
                    state_s = ST_POLL_SET;
                end else begin
                    gap_cnt_s = GAP_LOAD;
                    state_s   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == {GAP_W{1'b0}}) begin
                    state_s = ST_POLL_SET;
                end else begin
                    gap_cnt_s = gap_cnt_r - {{(GAP_W - 1){1'b0}}, 1'b1};
                end
            end
            ST_ACCEPT: begin
                if (handshake_s) begin
                    sram_address_s   = ADDR_DATA0 + count_r[7:0];
                    sram_writedata_s = pack_point(in_x, in_y, in_val);
                    sram_write_s     = 1'b1;
                    count_s          = count_inc_s;
                    if (in_last || batch_full_s) begin
                        // Drop ready on the closing handshake so no point is
                        // taken that would not fit in this batch.
                        in_ready_s = 1'b0;
                        overflow_s = !in_last;
                        state_s    = ST_WR_CNT;
                    end else begin
                        in_ready_s = 1'b1;
                    end
                end else begin
                    in_ready_s = 1'b1;
                end
            end
            ST_WR_CNT: begin
                sram_address_s   = ADDR_COUNT;
                sram_writedata_s = count_word(count_r);
                sram_write_s     = 1'b1;
                state_s          = ST_WR_FLAG;
            end
            ST_WR_FLAG: begin
                sram_address_s   = ADDR_FLAG;
                sram_writedata_s = FLAG_WORD;
                sram_write_s     = 1'b1;
                batch_sent_s     = 1'b1;
                state_s          = ST_POLL_SET;
            end
            default: begin
                state_s = ST_POLL_SET;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r          <= ST_POLL_SET;
            count_r          <= {COUNT_W{1'b0}};
            gap_cnt_r        <= {GAP_W{1'b0}};
            in_ready_r       <= 1'b0;
            sram_address_r   <= 8'd0;
            sram_write_r     <= 1'b0;
            sram_writedata_r <= 32'd0;
            busy_r           <= 1'b1;
            batch_sent_r     <= 1'b0;
            overflow_r       <= 1'b0;
        end else begin
            state_r          <= state_s;
            count_r          <= count_s;
            gap_cnt_r        <= gap_cnt_s;
            in_ready_r       <= in_ready_s;
            sram_address_r   <= sram_address_s;
            sram_write_r     <= sram_write_s;
            sram_writedata_r <= sram_writedata_s;
            busy_r           <= (state_s != ST_ACCEPT);
            batch_sent_r     <= batch_sent_s;
            overflow_r       <= overflow_s;
        end
    end

    assign in_ready       = in_ready_r;
    assign sram_address   = sram_address_r;
    assign sram_write     = sram_write_r;
    assign sram_writedata = sram_writedata_r;
    assign busy           = busy_r;
    assign batch_sent     = batch_sent_r;
    assign overflow       = overflow_r;

endmodule
